ov5640_sccb_master: RTL and testbench

//  Consumes OV5640 register-write commands (16-bit reg address + 8-bit data) queued by the HPS register block.

---
 rtl/ov5640_sccb_pkg.sv | 17 +
 rtl/sccb_tick_gen.sv | 29 ++
 rtl/ov5640_sccb_master.sv | 168 ++++++++++++++++
 tb/tb_ov5640_sccb_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_sccb_pkg.sv
// Shared types and constants for the OV5640 SCCB register-write master.
package ov5640_sccb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BYTE  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } sccb_state_t;

  localparam int          SCCB_BYTES   = 4;
  localparam int          SCCB_BITS    = 8;
  localparam logic [7:0]  OV5640_WR_ID = 8'h78;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick divider: pulses tick every QDIV clocks while run is high,
// and holds its count at zero while run is low.
module sccb_tick_gen #(
  parameter int QDIV = 125
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(QDIV);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(QDIV - 1));

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ov5640_sccb_master.sv
// Serialises one OV5640 register write (ID, addr hi, addr lo, data) per command
// as an SCCB 3-phase write, with a bus-free gap before accepting the next one.
module ov5640_sccb_master
  import ov5640_sccb_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         SCL_FREQ_HZ  = 100_000,
  parameter logic [7:0] DEV_ADDR     = OV5640_WR_ID,
  parameter int         GAP_QUARTERS = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start_ov5640,
  input  logic [15:0] address_ov5640,
  input  logic [7:0]  data_ov5640,
  output logic        ready_ov5640,
  output logic        sccb_scl,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_i,
  output logic        nack_err,
  output logic        busy
);

  localparam int QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  localparam int GW   = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;

  if (QDIV < 4) begin : g_qdiv_check
    $error("ov5640_sccb_master: QDIV must be at least 4");
  end

  sccb_state_t   state;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   shift;
  logic          sda_meta;
  logic          sda_sync;
  logic          nack_flag;
  logic          tick;

  sccb_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .tick    (tick)
  );

  // Combinational so ready drops in the strobe cycle and blocks a second FIFO pop.
  assign ready_ov5640 = (state == IDLE) && !start_ov5640;

  // NOTE: synchroniser flops reset to 1, the idle level of the pulled-up SIOD line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sccb_sda_i;
      sda_sync <= sda_meta;
    end
  end

  // Each tick closes the current quarter; the outputs assigned here belong to the next one.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      quarter     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      shift       <= '0;
      nack_flag   <= 1'b0;
      nack_err    <= 1'b0;
      busy        <= 1'b0;
      sccb_scl    <= 1'b1;
      sccb_sda_oe <= 1'b0;
    end else begin
      nack_err <= 1'b0;
      if (state == IDLE) begin
        quarter <= '0;
        if (start_ov5640) begin
          shift    <= {DEV_ADDR, address_ov5640, data_ov5640};
          bit_cnt  <= '0;
          byte_cnt <= '0;
          busy     <= 1'b1;
          state    <= START;
        end
      end else if (tick) begin
        quarter <= quarter + 2'd1;
        case (state)
          START: begin
            case (quarter)
              2'd1: sccb_sda_oe <= 1'b1;
              2'd2: sccb_scl    <= 1'b0;
              2'd3: begin
                state       <= BYTE;
                sccb_sda_oe <= ~shift[31];
              end
              default: ;
            endcase
          end
          BYTE: begin
            case (quarter)
              2'd0: sccb_scl <= 1'b1;
              2'd2: sccb_scl <= 1'b0;
              2'd3: begin
                shift <= {shift[30:0], 1'b0};
                if (bit_cnt == 3'(SCCB_BITS - 1)) begin
                  bit_cnt     <= '0;
                  state       <= ACK;
                  sccb_sda_oe <= 1'b0;
                end else begin
                  bit_cnt     <= bit_cnt + 3'd1;
                  sccb_sda_oe <= ~shift[30];
                end
              end
              default: ;
            endcase
          end
          ACK: begin
            case (quarter)
              2'd0: sccb_scl <= 1'b1;
              2'd2: begin
                sccb_scl <= 1'b0;
                if (sda_sync) nack_flag <= 1'b1;
              end
              2'd3: begin
                if (byte_cnt == 2'(SCCB_BYTES - 1)) begin
                  byte_cnt    <= '0;
                  state       <= STOP;
                  sccb_sda_oe <= 1'b1;
                end else begin
                  byte_cnt    <= byte_cnt + 2'd1;
                  state       <= BYTE;
                  sccb_sda_oe <= ~shift[31];
                end
              end
              default: ;
            endcase
          end
          STOP: begin
            case (quarter)
              2'd0: sccb_scl    <= 1'b1;
              2'd1: sccb_sda_oe <= 1'b0;
              2'd3: begin
                state     <= GAP;
                gap_cnt   <= '0;
                nack_err  <= nack_flag;
                nack_flag <= 1'b0;
              end
              default: ;
            endcase
          end
          GAP: begin
            if (gap_cnt == GW'(GAP_QUARTERS - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_master.sv
// Directed bench: SCCB slave model with pull-up and per-byte ack control,
// plus an upstream FIFO model, against ov5640_sccb_master at QDIV=10.
module tb_ov5640_sccb_master;

  localparam int QDIV       = 10;    // 50 MHz / (4 * 1.25 MHz)
  localparam int TXN_CYCLES = 1560;  // 156 quarters * 10
  localparam int SCL_PERIOD = 40;    // 4 quarters
  localparam int MIN_GAP    = 40;    // GAP_QUARTERS * QDIV
  localparam int NACK_DELAY = 20;    // stop edge (STOP q2 start) to GAP entry: q2 + q3

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_ov5640;
  logic [15:0] address_ov5640;
  logic [7:0]  data_ov5640;
  logic        ready_ov5640;
  logic        sccb_scl;
  logic        sccb_sda_oe;
  logic        nack_err;
  logic        busy;
  logic        slave_low = 1'b0;
  logic        sda_bus;

  assign sda_bus = !(sccb_sda_oe || slave_low);

  ov5640_sccb_master #(
    .CLK_FREQ_HZ  (50_000_000),
    .SCL_FREQ_HZ  (1_250_000),
    .DEV_ADDR     (8'h78),
    .GAP_QUARTERS (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .start_ov5640   (start_ov5640),
    .address_ov5640 (address_ov5640),
    .data_ov5640    (data_ov5640),
    .ready_ov5640   (ready_ov5640),
    .sccb_scl       (sccb_scl),
    .sccb_sda_oe    (sccb_sda_oe),
    .sccb_sda_i     (sda_bus),
    .nack_err       (nack_err),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SCCB slave model: start/stop/bit decode, ack drive, SCL period and gap measurement
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        prev_oe  = 1'b0;
  logic [3:0]  ack_mask = 4'hF;
  logic [7:0]  sh = '0;
  logic [7:0]  rx_q[$];
  int          gap_q[$];
  int          start_cnt = 0, stop_cnt = 0, stop_cyc = 0, act_cnt = 0;
  int          nack_cnt = 0, nack_cyc = 0, bit_idx = 0, byte_idx = 0;
  int          last_rise = 0, per_min = 0, per_max = 0;
  bit          have_rise = 1'b0, stop_seen = 1'b0;

  always @(negedge clk_sys) begin
    if (sccb_scl !== prev_scl || sccb_sda_oe !== prev_oe) act_cnt++;
    if (nack_err === 1'b1) begin
      nack_cnt++;
      nack_cyc = cyc;
    end
    if (sccb_scl && prev_scl && prev_sda && !sda_bus) begin
      start_cnt++;
      if (stop_seen) gap_q.push_back(cyc - stop_cyc);
      bit_idx   = 0;
      byte_idx  = 0;
      have_rise = 1'b0;
      per_min   = 1_000_000;
      per_max   = 0;
      slave_low = 1'b0;
    end else if (sccb_scl && prev_scl && !prev_sda && sda_bus) begin
      stop_cnt++;
      stop_cyc  = cyc;
      stop_seen = 1'b1;
    end else if (!prev_scl && sccb_scl) begin
      if (have_rise) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      have_rise = 1'b1;
      if (bit_idx < 8) sh = {sh[6:0], sda_bus};
      bit_idx++;
    end else if (prev_scl && !sccb_scl) begin
      if (bit_idx == 8) begin
        slave_low = (byte_idx < 4) ? ack_mask[byte_idx] : 1'b1;
      end else if (bit_idx == 9) begin
        slave_low = 1'b0;
        rx_q.push_back(sh);
        bit_idx = 0;
        byte_idx++;
      end
    end
    prev_scl = sccb_scl;
    prev_sda = sda_bus;
    prev_oe  = sccb_sda_oe;
  end

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    int g = 0;
    @(negedge clk_sys);
    while (ready_ov5640 !== 1'b1 && g < 5000) begin
      @(negedge clk_sys);
      g++;
    end
    check("ready_before_strobe", ready_ov5640, 1'b1);
    start_ov5640   = 1'b1;
    address_ov5640 = a;
    data_ov5640    = d;
    @(negedge clk_sys);
    start_ov5640   = 1'b0;
  endtask

  // Returns cycles with ready low after the strobe cycle, and busy-high cycles.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int inject_at,
                          output int low_cnt, output int busy_cnt);
    int g = 0;
    strobe(a, d);
    low_cnt  = 0;
    busy_cnt = 0;
    while (ready_ov5640 !== 1'b1 && g < 4000) begin
      if (busy === 1'b1) busy_cnt++;
      low_cnt++;
      if (low_cnt == inject_at) begin
        start_ov5640   = 1'b1;
        address_ov5640 = 16'hDEAD;
        data_ov5640    = 8'hBE;
      end else begin
        start_ov5640 = 1'b0;
      end
      @(negedge clk_sys);
      g++;
    end
    start_ov5640 = 1'b0;
  endtask

  task automatic check_rx(input string tag, input int base, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] exp_b [4];
    logic [7:0] got_b;
    exp_b = '{8'h78, a[15:8], a[7:0], d};
    check({tag, "_nbytes"}, rx_q.size() - base >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got_b = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), got_b, exp_b[i]);
    end
  endtask

  initial begin
    int low, bcnt, s0, p0, n0, b0, a0, g, pops;
    logic r, pend;
    logic [23:0] fifo[$];
    logic [23:0] pc;

    start_ov5640   = 1'b0;
    address_ov5640 = '0;
    data_ov5640    = '0;

    // 1: reset values, then a quiet idle bus with ready high
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_scl",  sccb_scl,    1'b1);
    check("rst_oe",   sccb_sda_oe, 1'b0);
    check("rst_busy", busy,        1'b0);
    check("rst_nack", nack_err,    1'b0);
    reset_n = 1'b1;
    a0  = act_cnt;
    low = 0;
    repeat (1000) begin
      @(negedge clk_sys);
      if (ready_ov5640 !== 1'b1) low++;
    end
    check("idle_ready_low_cycles", low, 0);
    check("idle_bus_activity", act_cnt - a0, 0);

    // 2: single write 0x3008 <= 0x82
    s0 = start_cnt; p0 = stop_cnt; n0 = nack_cnt; b0 = rx_q.size();
    do_write(16'h3008, 8'h82, -1, low, bcnt);
    check("w1_starts", start_cnt - s0, 1);
    check("w1_stops",  stop_cnt - p0,  1);
    check_rx("w1", b0, 16'h3008, 8'h82);
    check("w1_nack",       nack_cnt - n0, 0);
    check("w1_ready_low",  low,  TXN_CYCLES);
    check("w1_busy",       bcnt, TXN_CYCLES);
    check("w1_scl_per_min", per_min, SCL_PERIOD);
    check("w1_scl_per_max", per_max, SCL_PERIOD);

    // 3: FIFO of three commands popped with rdreq = !empty & ready
    fifo = '{ {16'h3103, 8'h11}, {16'h3008, 8'h02}, {16'h3017, 8'hFF} };
    s0 = start_cnt; p0 = stop_cnt; n0 = nack_cnt; b0 = rx_q.size();
    pops = 0; pend = 1'b0; pc = '0; g = 0;
    while (g < 8000) begin
      @(negedge clk_sys);
      g++;
      if (pend) begin
        start_ov5640   = 1'b1;
        address_ov5640 = pc[23:8];
        data_ov5640    = pc[7:0];
        pend           = 1'b0;
      end else begin
        start_ov5640 = 1'b0;
      end
      #1;
      r = ready_ov5640;
      if (r && fifo.size() > 0) begin
        pc   = fifo.pop_front();
        pend = 1'b1;
        pops++;
      end
      if (fifo.size() == 0 && !pend && !start_ov5640 && r) break;
    end
    start_ov5640 = 1'b0;
    check("fifo_pops",   pops, 3);
    check("fifo_starts", start_cnt - s0, 3);
    check("fifo_stops",  stop_cnt - p0,  3);
    check_rx("fifo0", b0,     16'h3103, 8'h11);
    check_rx("fifo1", b0 + 4, 16'h3008, 8'h02);
    check_rx("fifo2", b0 + 8, 16'h3017, 8'hFF);
    check("fifo_gap1", gap_q.size() >= 2 && gap_q[gap_q.size() - 2] >= MIN_GAP, 1'b1);
    check("fifo_gap2", gap_q.size() >= 1 && gap_q[gap_q.size() - 1] >= MIN_GAP, 1'b1);
    check("fifo_nack", nack_cnt - n0, 0);

    // 4: strobe while busy is ignored
    s0 = start_cnt; p0 = stop_cnt; b0 = rx_q.size();
    do_write(16'h5001, 8'h03, 400, low, bcnt);
    repeat (100) @(negedge clk_sys);
    check("inj_starts", start_cnt - s0, 1);
    check("inj_stops",  stop_cnt - p0,  1);
    check_rx("inj", b0, 16'h5001, 8'h03);
    check("inj_ready_low", low, TXN_CYCLES);
    check("inj_idle_busy", busy, 1'b0);

    // 5: second byte not acked -> one nack_err pulse at stop exit, transfer completes
    ack_mask = 4'b1101;
    s0 = start_cnt; p0 = stop_cnt; n0 = nack_cnt; b0 = rx_q.size();
    do_write(16'h4300, 8'h30, -1, low, bcnt);
    check("nack_stops", stop_cnt - p0, 1);
    check_rx("nack", b0, 16'h4300, 8'h30);
    check("nack_pulse_cycles", nack_cnt - n0, 1);
    check("nack_pulse_pos", nack_cyc - stop_cyc, NACK_DELAY);
    ack_mask = 4'hF;
    n0 = nack_cnt; b0 = rx_q.size();
    do_write(16'h4301, 8'h31, -1, low, bcnt);
    check_rx("ackok", b0, 16'h4301, 8'h31);
    check("ackok_nack", nack_cnt - n0, 0);

    // 6: reset during the address-low byte (quarter 95: bit 4 of 0x12, SCL low, SDA driven low)
    strobe(16'h3212, 8'h00);
    repeat (955) @(negedge clk_sys);
    check("pre_rst_scl", sccb_scl,    1'b0);
    check("pre_rst_oe",  sccb_sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_scl",  sccb_scl,    1'b1);
    check("midrst_oe",   sccb_sda_oe, 1'b0);
    check("midrst_busy", busy,        1'b0);
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    s0 = start_cnt; p0 = stop_cnt; b0 = rx_q.size();
    do_write(16'h3008, 8'h82, -1, low, bcnt);
    check("postrst_starts", start_cnt - s0, 1);
    check("postrst_stops",  stop_cnt - p0,  1);
    check_rx("postrst", b0, 16'h3008, 8'h82);
    check("postrst_ready_low", low, TXN_CYCLES);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
